// File: rtl/dsram_resp_pkg.sv
// Shared bus widths, MMIO map and UART state encoding
// for the data-SRAM responder.
package dsram_resp_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic [15:0] MMIO_BASE     = 16'hbfaf;
  localparam logic [15:0] OFF_TIMER     = 16'he000;
  localparam logic [15:0] OFF_LED       = 16'hf000;
  localparam logic [15:0] OFF_UART_DATA = 16'hf010;
  localparam logic [15:0] OFF_UART_STAT = 16'hf014;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LED,
    SEL_TIMER,
    SEL_UDATA,
    SEL_USTAT,
    SEL_NONE
  } sel_e;

  function automatic logic [BUS_DW-1:0] merge32(
    input logic [BUS_DW-1:0] i_old,
    input logic [BUS_DW-1:0] i_new,
    input logic [3:0]        i_we
  );
    logic [BUS_DW-1:0] w_res;
    w_res = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_we[i]) w_res[8*i +: 8] = i_new[8*i +: 8];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/dsram_resp_uart_tx.sv
// 8N1 UART transmitter, UART_DIV clocks per bit,
// LSB first; start is ignored unless idle.
module uart_tx
  import dsram_resp_pkg::*;
#(
  parameter int UART_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam logic [15:0] LAST = 16'(UART_DIV - 1);

  uart_state_e r_state;
  uart_state_e w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= UART_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_last      = (r_cnt == LAST);
    unique case (r_state)
      UART_IDLE: begin
        if (start) begin
          w_state_nxt = UART_START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_shift_nxt = data;
        end
      end
      UART_START: begin
        if (w_last) begin
          w_state_nxt = UART_DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      UART_DATA: begin
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = UART_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      UART_STOP: begin
        if (w_last) begin
          w_state_nxt = UART_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = UART_IDLE;
    endcase
  end

  assign busy = (r_state != UART_IDLE);
  assign txd  = (r_state == UART_START) ? 1'b0 :
                (r_state == UART_DATA)  ? r_shift[0] :
                1'b1;

endmodule

// File: rtl/dsram_resp.sv
// Data-SRAM responder: word RAM plus LED, timer
// and UART registers in the 0xbfaf MMIO window.
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int UART_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic        uart_txd
);

  logic [31:0] r_mem [0:(2**RAM_AW)-1];
  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_timer;

  logic              w_mmio;
  logic [15:0]       w_off;
  logic [RAM_AW-1:0] w_word;
  sel_e              w_sel;
  logic              w_acc;
  logic              w_wr;
  logic [31:0]       w_rd;
  logic              w_busy;
  logic              w_start;
  logic              w_unused;

  assign w_mmio   = (data_sram_addr[31:16] == MMIO_BASE);
  assign w_off    = data_sram_addr[15:0];
  assign w_word   = data_sram_addr[RAM_AW+1:2];
  assign w_acc    = data_sram_en & ~reset;
  assign w_wr     = w_acc & (|data_sram_we);
  assign w_unused = ^data_sram_addr[1:0];

  // Offsets compare on word bits only; byte lane is ignored.
  always_comb begin
    w_sel = SEL_NONE;
    if (!w_mmio) begin
      w_sel = SEL_RAM;
    end else begin
      unique case (1'b1)
        (w_off[15:2] == OFF_LED[15:2]):       w_sel = SEL_LED;
        (w_off[15:2] == OFF_TIMER[15:2]):     w_sel = SEL_TIMER;
        (w_off[15:2] == OFF_UART_DATA[15:2]): w_sel = SEL_UDATA;
        (w_off[15:2] == OFF_UART_STAT[15:2]): w_sel = SEL_USTAT;
        default:                              w_sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (w_sel)
      SEL_RAM:   w_rd = r_mem[w_word];
      SEL_LED:   w_rd = {16'h0, r_led};
      SEL_TIMER: w_rd = r_timer;
      SEL_USTAT: w_rd = {31'h0, w_busy};
      default:   w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr && (w_sel == SEL_RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          r_mem[w_word][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (data_sram_en) begin
      r_rdata <= w_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_wr && (w_sel == SEL_LED)) begin
      if (data_sram_we[0]) r_led[7:0]  <= data_sram_wdata[7:0];
      if (data_sram_we[1]) r_led[15:8] <= data_sram_wdata[15:8];
    end
  end

  // Bytes not enabled keep the value held before the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_wr && (w_sel == SEL_TIMER)) begin
      r_timer <= merge32(r_timer, data_sram_wdata, data_sram_we);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end

  assign w_start = w_acc & (w_sel == SEL_UDATA) &
                   data_sram_we[0] & ~w_busy;

  uart_tx #(
    .UART_DIV(UART_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .reset(reset),
    .start(w_start),
    .data (data_sram_wdata[7:0]),
    .busy (w_busy),
    .txd  (uart_txd)
  );

  assign data_sram_rdata = r_rdata;
  assign led             = r_led;

endmodule

// File: tb/tb_dsram_resp.sv
// Randomized bench for dsram_resp against a cycle-indexed
// behavioural model, plus directed literal scenarios.
module tb_dsram_resp;

  localparam int AW  = 6;
  localparam int DIV = 4;
  localparam int NW  = 1 << AW;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        txd;

  always #5 clk = ~clk;

  dsram_resp #(
    .RAM_AW  (AW),
    .UART_DIV(DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (en),
    .data_sram_we   (we),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .led            (led),
    .uart_txd       (txd)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [NW];
  logic [31:0] m_rdata;
  logic [31:0] m_timer;
  logic [15:0] m_led;
  longint      cyc     = 0;
  bit          f_valid = 0;
  longint      f_start = 0;
  logic [7:0]  f_data  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mrg(logic [31:0] o,
                                      logic [31:0] n,
                                      logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // A frame written in cycle s occupies cycles s+1 .. s+10*DIV.
  function automatic bit m_busy(longint c);
    return f_valid && (c >= f_start + 1) &&
           (c <= f_start + 10 * DIV);
  endfunction

  function automatic logic m_txd(longint c);
    longint k;
    if (!m_busy(c)) return 1'b1;
    k = (c - f_start - 1) / DIV;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return f_data[k-1];
  endfunction

  task automatic model_step(bit r, bit e, logic [3:0] b,
                            logic [31:0] a, logic [31:0] d);
    logic [31:0] rv;
    logic [31:0] nt;
    logic [15:0] off;
    int          idx;
    bit          tw;
    rv = 0;
    tw = 0;
    nt = m_timer + 1;
    if (r) begin
      m_rdata = 0;
      m_led   = 0;
      m_timer = 0;
      f_valid = 0;
    end else begin
      if (e) begin
        if (a[31:16] != 16'hbfaf) begin
          idx = int'(a[AW+1:2]);
          rv  = m_mem[idx];
          m_mem[idx] = mrg(m_mem[idx], d, b);
        end else begin
          off = a[15:0] & 16'hfffc;
          case (off)
            16'hf000: begin
              rv = {16'h0, m_led};
              m_led = 16'(mrg({16'h0, m_led}, d, {2'b00, b[1:0]}));
            end
            16'he000: begin
              rv = m_timer;
              if (b != 0) begin
                tw = 1;
                nt = mrg(m_timer, d, b);
              end
            end
            16'hf010: begin
              if (b[0] && !m_busy(cyc)) begin
                f_valid = 1;
                f_start = cyc;
                f_data  = d[7:0];
              end
            end
            16'hf014: rv = {31'h0, m_busy(cyc)};
            default:  rv = 0;
          endcase
        end
        m_rdata = rv;
      end
      m_timer = tw ? nt : m_timer + 1;
    end
    cyc++;
  endtask

  task automatic tick(bit r, bit e, logic [3:0] b,
                      logic [31:0] a, logic [31:0] d);
    reset = r;
    en    = e;
    we    = b;
    addr  = a;
    wdata = d;
    @(posedge clk);
    model_step(r, e, b, a, d);
    #1;
    chk("rdata", rdata, m_rdata);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("txd", {31'h0, txd}, {31'h0, m_txd(cyc)});
  endtask

  task automatic idle();
    tick(0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [9:0]  pat;
  logic [31:0] ra;
  logic [15:0] offs [6];
  int          s41;

  initial begin
    offs[0] = 16'hf000; offs[1] = 16'he000;
    offs[2] = 16'hf010; offs[3] = 16'hf014;
    offs[4] = 16'hf018; offs[5] = 16'h0000;

    for (int i = 0; i < 3; i++)
      tick(1, 1, 4'hf, 32'h0, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0);
    chk("reset_txd", {31'h0, txd}, 32'h1);

    for (int i = 0; i < NW; i++)
      tick(0, 1, 4'hf, i * 4, 32'h0);

    tick(0, 1, 4'hf, 32'h100, 32'h12345678);
    tick(0, 1, 4'h2, 32'h100, 32'hAABBCCDD);
    tick(0, 1, 4'h0, 32'h100, 32'h0);
    chk("ram_bytewrite", rdata, 32'h1234CC78);
    idle();
    chk("rdata_hold", rdata, 32'h1234CC78);

    tick(0, 1, 4'h3, 32'hbfaff000, 32'h000000A5);
    tick(0, 1, 4'h0, 32'hbfaff000, 32'h0);
    chk("led_read", rdata, 32'h000000A5);
    chk("led_port", {16'h0, led}, 32'h000000A5);

    tick(0, 1, 4'hf, 32'hbfafe000, 32'hFFFFFFFE);
    idle(); idle(); idle();
    tick(0, 1, 4'h0, 32'hbfafe000, 32'h0);
    chk("timer_wrap", rdata, 32'h00000001);

    pat = 10'b1010101010;
    tick(0, 1, 4'h1, 32'hbfaff010, 32'h55);
    for (int j = 0; j < 48; j++) begin
      chk("uart_bit", {31'h0, txd},
          (j < 40) ? {31'h0, pat[j/4]} : 32'h1);
      if (j == 19) begin
        tick(0, 1, 4'h1, 32'hbfaff010, 32'hFF);
      end else if (j % 2 == 0) begin
        tick(0, 1, 4'h0, 32'hbfaff014, 32'h0);
        chk("uart_status", rdata, (j < 40) ? 32'h1 : 32'h0);
      end else begin
        idle();
      end
    end

    tick(0, 1, 4'hf, 32'h20, 32'hDEADBEEF);
    tick(0, 1, 4'h1, 32'hbfaff010, 32'h55);
    for (s41 = 0; s41 < 14; s41++) idle();
    chk("pre_reset_txd", {31'h0, txd}, 32'h1);
    tick(1, 0, 4'h0, 32'h0, 32'h0);
    chk("abort_txd", {31'h0, txd}, 32'h1);
    tick(0, 1, 4'h0, 32'hbfaff014, 32'h0);
    chk("abort_status", rdata, 32'h0);
    tick(0, 1, 4'h0, 32'h20, 32'h0);
    chk("ram_kept", rdata, 32'hDEADBEEF);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        tick(1, 1'($urandom), 4'($urandom),
             $urandom, $urandom);
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          ra = {16'hbfaf, offs[$urandom_range(0, 5)]};
          ra[1:0] = 2'($urandom);
        end else begin
          ra = $urandom;
          if (ra[31:16] == 16'hbfaf) ra[31] = 1'b0;
        end
        tick(0, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
             ra, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dsram_resp.md
DSRAM_RESP -- requirements
Module: dsram_resp

Interface
REQ-001 Parameter RAM_AW, default 10, sets the RAM size: word-address width, giving 2^RAM_AW 32-bit words.
REQ-002 Parameter UART_DIV, default 16, sets the clock cycles per UART bit; legal range is 2..65535.
REQ-003 Port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, width 1: reset is synchronous and active-high.
REQ-005 Port data_sram_en, input, width 1: access request, valid this cycle.
REQ-006 Port data_sram_we, input, width 4: byte write enables; bit i covers wdata[8i+7:8i]; all zero means a read.
REQ-007 Port data_sram_addr, input, width 32: byte address; bits [1:0] are ignored.
REQ-008 Port data_sram_wdata, input, width 32: write data.
REQ-009 Port data_sram_rdata, output, width 32: read data, registered.
REQ-010 Port led, output, width 16: LED register.
REQ-011 Port uart_txd, output, width 1: serial transmit line, idle high.

Function
REQ-012 The block SHALL decode addr[31:16]==16'hbfaf as MMIO; all other addresses SHALL map to RAM word addr[RAM_AW+1:2], with upper bits aliasing.
REQ-013 On a cycle with en=1, rdata SHALL present the addressed word on the next cycle (1-cycle latency, no stall, request accepted every cycle).
REQ-014 On a cycle with en=0, rdata SHALL hold its previous value.
REQ-015 A RAM write (en=1, we!=0) SHALL update only the enabled bytes; rdata for that access SHALL return the pre-write word (read-first).
REQ-016 The LED register at offset 16'hf000 SHALL be read/write, with 16 bits in [15:0]; reads SHALL zero-extend; a write SHALL require we[0] for bits [7:0] and we[1] for bits [15:8].
REQ-017 The timer at offset 16'he000 SHALL be a 32-bit counter incrementing by 1 every cycle and wrapping from 32'hffffffff to 0.
REQ-018 A timer write SHALL load wdata (byte enables honoured) and take priority over the increment in that cycle.
REQ-019 A timer read SHALL return the value held in the request cycle.
REQ-020 UART_DATA at offset 16'hf010: a write with we[0]=1 while the UART is idle SHALL start transmission of wdata[7:0]; a write while busy SHALL be dropped; reads SHALL return 0.
REQ-021 UART_STATUS at offset 16'hf014 SHALL be read-only, with bit0 = busy and other bits 0; writes SHALL be ignored.
REQ-022 Unmapped MMIO offsets SHALL read 0 and ignore writes.
REQ-023 The UART FSM SHALL have states IDLE, START, DATA and STOP.
REQ-024 IDLE->START SHALL occur on an accepted write, with txd=0 from the next cycle.
REQ-025 START SHALL last UART_DIV cycles, then the FSM SHALL enter DATA.
REQ-026 DATA SHALL send 8 bits LSB-first, each lasting UART_DIV cycles.
REQ-027 STOP SHALL drive txd=1 for UART_DIV cycles, then the FSM SHALL return to IDLE.
REQ-028 busy SHALL be 1 in START, DATA and STOP, so a frame occupies 10*UART_DIV cycles.
REQ-029 A UART_DATA write in the same cycle as the STOP->IDLE transition SHALL be dropped, because busy is still 1.

Reset
REQ-030 While reset=1 the block SHALL force rdata=0, led=0, timer=0, UART state IDLE, uart_txd=1 and the bit/cycle counters to 0.
REQ-031 A reset asserted mid-frame SHALL abort the frame, with txd high the following cycle.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Accesses presented during reset SHALL be ignored.

Structure
REQ-034 The MMIO base and offsets, and the UART state encoding, SHALL live in a shared package/header alongside the existing bus-width defines.
REQ-035 The UART transmitter SHALL be a sub-module uart_tx with ports clk, reset, start, data[7:0], busy and txd.
REQ-036 The RAM array, decode, LED register and timer SHALL reside in dsram_resp.

Verification
REQ-037 Write 32'h12345678 with we=4'b1111 to 0x100, then write we=4'b0010 with wdata 32'hAABBCCDD to 0x100, then read 0x100 -> rdata=32'h1234CC78 one cycle after the read request.
REQ-038 Write led=0x00A5 at 0xbfaff000, then read -> rdata=32'h000000A5 and led=16'h00A5.
REQ-039 Write timer 0xFFFFFFFE at 0xbfafe000, then read 3 cycles later -> rdata=32'h00000001 (wrap verified).
REQ-040 With UART_DIV=4, write 0x55 to 0xbfaff010 -> txd pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; STATUS reads 1 during the frame and 0 after 40 cycles; a second write at cycle 20 is dropped, so no second frame follows.
REQ-041 Assert reset at cycle 15 of a frame -> txd=1 and STATUS=0 the next cycle; a RAM word written before reset still reads back its value.
